pipelined_shifter: RTL and testbench
====================================

# pipelined_shifter

Parametrised, pipelined shift/rotate unit supporting logical and arithmetic right shift, logical left shift, and both rotates. It generalises the team's 8-bit combinational funnel shifter: operand width is a parameter, there is one register stage per shift-amount bit, and a valid/ready handshake with full-pipeline stall is added. It sits between an operand-issue stage and the register-file writeback of the datapath.

## Interface
- `WIDTH`, default 8: operand width; must be a power of two, ≥ 2.
- `SHW`, default `$clog2(WIDTH)`: shift-amount width and pipeline depth; derived, never overridden.
- `clk`  in  1: clock; all state updates on the rising edge.
- `rst`  in  1: reset, synchronous, active-high.
- `in_valid`  in  1: an operation is presented.
- `in_ready`  out  1: the unit accepts the operation this cycle.
- `in_data`  in  WIDTH: operand.
- `in_n`  in  SHW: shift amount, 0..WIDTH-1.
- `in_op`  in  3: operation code (`shift_pkg::op_t`).
- `out_valid`  out  1: a result is presented.
- `out_ready`  in  1: the consumer takes the result.
- `out_data`  out  WIDTH: result.
- `out_zero`  out  1: `out_data == 0`.
- `out_illegal`  out  1: the op code was undefined; `out_data` holds the unmodified operand.

## Operation
- Op codes: SRL=0 (fill 0), SRA=1 (fill sign bit), SLL=2 (fill 0), ROR=3, ROL=4. Codes 5..7 are illegal and pass through with `out_illegal`=1.
- Left ops (SLL, ROL) bit-reverse the operand at entry and the result at exit, so every stage performs only right shifts.
- Stage k (k = 0..SHW-1) shifts right by 2^k when bit k of the carried amount is set, otherwise passes the word through. The fill comes from the carried mode: zeros (SRL/SLL), a replicated sign bit captured at entry (SRA), or the word's own low bits (ROR/ROL).
- Each stage register carries: data, remaining amount, op, sign, valid.
- Amount 0 returns the operand unchanged for every op. The amount is never ≥ WIDTH by construction, so no saturation case exists.
- Handshake: `advance = !out_valid || out_ready`. The whole pipe shifts one stage when `advance` is high, and all registers hold otherwise. `in_ready = advance`, which is combinational from `out_valid` and `out_ready`.
- An operation is accepted when `in_valid && in_ready`. A bubble (valid=0) enters when `advance && !in_valid`.
- `out_data`, `out_zero` and `out_illegal` are stable while `out_valid && !out_ready`.
- Reset: every stage valid=0 and data=0; `out_valid`=0, `out_data`=0, `out_zero`=0, `out_illegal`=0. `in_ready`=1 in the first cycle after reset.
- Reset asserted mid-operation discards all in-flight ops with no output. An input presented in a cycle with `rst`=1 is not accepted.

## Timing
- Latency: SHW cycles from acceptance to `out_valid` (3 for WIDTH=8) when no stall occurs.
- Throughput: one op per cycle while `out_ready`=1.
- Backpressure: if `out_ready`=0 while `out_valid`=1, `in_ready` drops in the same cycle, and no op is lost or duplicated.
- With `out_ready` tied to 1, `in_ready` is constantly 1.
- Capacity: SHW ops in flight.
- `out_zero` is computed from the final stage register, not from the bus.

## Structure
- Package `shift_pkg`: `op_t` enum (SRL, SRA, SLL, ROR, ROL), an `is_left(op)` function, and an `is_legal(op)` function.
- Sub-module `shift_stage`, parameters `WIDTH` and `K`: combinational, shifts by 2^K with a fill selected by mode. The top instantiates SHW copies of it through a generate loop, each followed by its pipeline register.
- Top level contains the entry and exit reversal muxes, the stage registers, and the handshake logic.

## Test plan
- WIDTH=8, `in_data`=0x96, `in_n`=3, one op each with `out_ready`=1 → results after 3 cycles: SRL 0x12, SRA 0xF2, SLL 0xB0, ROR 0xD2, ROL 0xB4.
- `in_n`=0 for all five ops on 0x96 → 0x96 each. SRL 0x01 by 1 → 0x00 with `out_zero`=1.
- Back-to-back stream of 10 random ops with `out_ready`=1 → one result per cycle, in order, matching the reference model.
- Hold `out_ready`=0 for 4 cycles with 3 ops in flight → `in_ready`=0, outputs frozen. After release, all 3 results appear in order with no loss or duplication.
- `in_op`=6, `in_data`=0x5A → `out_data`=0x5A, `out_illegal`=1.
- Assert `rst` for one cycle with 2 ops in flight → `out_valid`=0 next cycle and no stale results afterwards. Repeat at WIDTH=32: SRA 0x8000_0000 by 31 → 0xFFFF_FFFF with 5-cycle latency.

Source files
------------

// File: rtl/shift_pkg.sv
// Shared op codes and op decode helpers for the pipelined shift/rotate unit.
package shift_pkg;

    typedef enum logic [2:0] {
        OP_SRL = 3'd0,
        OP_SRA = 3'd1,
        OP_SLL = 3'd2,
        OP_ROR = 3'd3,
        OP_ROL = 3'd4
    } op_t;

    typedef enum logic [1:0] {
        FILL_ZERO,
        FILL_SIGN,
        FILL_ROT
    } fill_t;

    function automatic logic is_left(op_t op);
        return (op == OP_SLL) || (op == OP_ROL);
    endfunction

    function automatic logic is_legal(op_t op);
        return op <= OP_ROL;
    endfunction

    // Left ops run reversed through the right-only stages, so ROL fills like ROR.
    function automatic fill_t fill_of(op_t op);
        case (op)
            OP_SRA:         return FILL_SIGN;
            OP_ROR, OP_ROL: return FILL_ROT;
            default:        return FILL_ZERO;
        endcase
    endfunction

endpackage

// File: rtl/shift_stage.sv
// One combinational funnel step: right shift by 2^K when enabled, fill chosen by mode.
module shift_stage
    import shift_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int K     = 0
) (
    input  logic [WIDTH-1:0] data,
    input  logic             en,
    input  fill_t            mode,
    input  logic             sign,
    output logic [WIDTH-1:0] res
);

    localparam int S = 1 << K;

    logic [S-1:0] fill;

    always_comb begin
        fill = '0;
        case (mode)
            FILL_SIGN: fill = {S{sign}};
            FILL_ROT:  fill = data[S-1:0];
            default:   fill = '0;
        endcase
        res = en ? {fill, data[WIDTH-1:S]} : data;
    end

endmodule

// File: rtl/pipelined_shifter.sv
// Pipelined shift/rotate unit: one register stage per shift-amount bit, whole-pipe stall
// on output backpressure.
module pipelined_shifter
    import shift_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int SHW   = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    input  logic [SHW-1:0]   in_n,
    input  logic [2:0]       in_op,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic             out_zero,
    output logic             out_illegal
);

    function automatic logic [WIDTH-1:0] rev(input logic [WIDTH-1:0] x);
        logic [WIDTH-1:0] r;
        for (int i = 0; i < WIDTH; i++) r[i] = x[WIDTH-1-i];
        return r;
    endfunction

    logic             advance;
    op_t              e_op;
    logic [WIDTH-1:0] e_data;
    logic [SHW-1:0]   e_amt;
    logic             e_sign;

    assign advance  = !out_valid || out_ready;
    assign in_ready = advance;

    // Illegal ops get a zero amount so the operand rides through untouched.
    always_comb begin
        e_op   = op_t'(in_op);
        e_data = is_left(e_op) ? rev(in_data) : in_data;
        e_amt  = is_legal(e_op) ? in_n : '0;
        e_sign = in_data[WIDTH-1];
    end

    for (genvar k = 0; k < SHW; k++) begin : g_stg
        // Only the amount bits not yet consumed travel on, so the tail carries none.
        logic [SHW-1-k:0] amt_in;
        logic [WIDTH-1:0] d_in;
        logic [WIDTH-1:0] shifted;
        op_t              op_in;
        logic             sg_in;
        logic             v_in;
        logic [WIDTH-1:0] d_q;
        op_t              op_q;
        logic             v_q;

        if (k == 0) begin : g_src
            assign amt_in = e_amt;
            assign d_in   = e_data;
            assign op_in  = e_op;
            assign sg_in  = e_sign;
            assign v_in   = in_valid;
        end else begin : g_src
            assign amt_in = g_stg[k-1].g_carry.amt_q;
            assign d_in   = g_stg[k-1].d_q;
            assign op_in  = g_stg[k-1].op_q;
            assign sg_in  = g_stg[k-1].g_carry.sg_q;
            assign v_in   = g_stg[k-1].v_q;
        end

        shift_stage #(.WIDTH(WIDTH), .K(k)) u_stage (
            .data (d_in),
            .en   (amt_in[0]),
            .mode (fill_of(op_in)),
            .sign (sg_in),
            .res  (shifted)
        );

        always_ff @(posedge clk) begin
            if (rst) begin
                v_q  <= 1'b0;
                d_q  <= '0;
                op_q <= OP_SRL;
            end else if (advance) begin
                v_q  <= v_in;
                d_q  <= shifted;
                op_q <= op_in;
            end
        end

        if (k < SHW - 1) begin : g_carry
            logic [SHW-2-k:0] amt_q;
            logic             sg_q;

            always_ff @(posedge clk) begin
                if (rst) begin
                    amt_q <= '0;
                    sg_q  <= 1'b0;
                end else if (advance) begin
                    amt_q <= amt_in[SHW-1-k:1];
                    sg_q  <= sg_in;
                end
            end
        end
    end

    logic [WIDTH-1:0] last_data;
    op_t              last_op;

    assign last_data   = g_stg[SHW-1].d_q;
    assign last_op     = g_stg[SHW-1].op_q;
    assign out_valid   = g_stg[SHW-1].v_q;
    assign out_data    = is_left(last_op) ? rev(last_data) : last_data;
    assign out_zero    = out_valid && (last_data == '0);
    assign out_illegal = out_valid && !is_legal(last_op);

endmodule

// File: tb/tb_pipelined_shifter.sv
// Randomized and directed bench for pipelined_shifter at WIDTH=8 and WIDTH=32.
module tb_pipelined_shifter;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst;

    logic       iv8, ir8, ov8, or8, oz8, oi8;
    logic [7:0] id8, od8;
    logic [2:0] in8, iop8;

    logic        iv32, ir32, ov32, or32, oz32, oi32;
    logic [31:0] id32, od32;
    logic [4:0]  in32;
    logic [2:0]  iop32;

    pipelined_shifter #(.WIDTH(8)) u_dut8 (
        .clk(clk), .rst(rst),
        .in_valid(iv8), .in_ready(ir8), .in_data(id8), .in_n(in8), .in_op(iop8),
        .out_valid(ov8), .out_ready(or8), .out_data(od8), .out_zero(oz8), .out_illegal(oi8)
    );

    pipelined_shifter #(.WIDTH(32)) u_dut32 (
        .clk(clk), .rst(rst),
        .in_valid(iv32), .in_ready(ir32), .in_data(id32), .in_n(in32), .in_op(iop32),
        .out_valid(ov32), .out_ready(or32), .out_data(od32), .out_zero(oz32), .out_illegal(oi32)
    );

    int checks = 0;
    int errors = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Reference: plain arithmetic on a 64-bit copy of the operand.
    function automatic logic [31:0] model(input int w, input logic [31:0] d, input int n, input int op);
        logic [63:0] m, x, r;
        m = (64'd1 << w) - 64'd1;
        x = {32'd0, d} & m;
        case (op)
            0: r = x >> n;
            1: begin
                if (x[w-1]) x = x | ~m;
                r = x >> n;
            end
            2: r = x << n;
            3: r = (x >> n) | (x << (w - n));
            4: r = (x << n) | (x >> (w - n));
            default: r = x;
        endcase
        r = r & m;
        return r[31:0];
    endfunction

    typedef struct {
        logic [7:0] d;
        logic       z;
        logic       il;
        int         acc;
    } exp_t;

    exp_t q[$];
    int   cyc = 0;
    bit   exact_lat = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    // Scoreboard for the 8-bit unit: pop on every output handshake, push on every acceptance.
    always @(negedge clk) begin
        if (rst) begin
            q.delete();
        end else begin
            if (ov8 && or8) begin
                chk("spurious_out", 32'(ov8), 32'(q.size() != 0));
                if (q.size() != 0) begin
                    exp_t e;
                    e = q.pop_front();
                    chk("data8", 32'(od8), 32'(e.d));
                    chk("zero8", 32'(oz8), 32'(e.z));
                    chk("illegal8", 32'(oi8), 32'(e.il));
                    if (exact_lat) chk("latency8", 32'(cyc - e.acc), 32'd3);
                end
            end
            if (iv8 && ir8) begin
                exp_t e;
                e.d   = model(8, 32'(id8), int'(in8), int'(iop8)) & 32'hFF;
                e.z   = (e.d == 8'd0);
                e.il  = (iop8 > 3'd4);
                e.acc = cyc;
                q.push_back(e);
            end
        end
    end

    task automatic drive8(input logic [7:0] d, input int n, input int op);
        @(posedge clk);
        #1;
        iv8  = 1'b1;
        id8  = d;
        in8  = 3'(n);
        iop8 = 3'(op);
    endtask

    task automatic idle8(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
            iv8 = 1'b0;
        end
    endtask

    task automatic run32(input logic [31:0] d, input int n, input int op);
        int lat;
        @(posedge clk);
        #1;
        iv32  = 1'b1;
        id32  = d;
        in32  = 5'(n);
        iop32 = 3'(op);
        @(negedge clk);
        chk("in_ready32", 32'(ir32), 32'd1);
        @(posedge clk);
        #1;
        iv32 = 1'b0;
        lat = 0;
        do begin
            @(negedge clk);
            lat++;
        end while (!ov32 && lat < 20);
        chk("latency32", 32'(lat), 32'd5);
        chk("data32", od32, model(32, d, n, op));
        chk("zero32", 32'(oz32), 32'(model(32, d, n, op) == 32'd0));
        chk("illegal32", 32'(oi32), 32'(op > 4));
    endtask

    initial begin
        logic [31:0] e;
        rst = 1'b1;
        iv8 = 1'b0; id8 = '0; in8 = '0; iop8 = '0; or8 = 1'b1;
        iv32 = 1'b0; id32 = '0; in32 = '0; iop32 = '0; or32 = 1'b1;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;

        @(negedge clk);
        chk("rst_out_valid", 32'(ov8), 32'd0);
        chk("rst_out_data", 32'(od8), 32'd0);
        chk("rst_out_zero", 32'(oz8), 32'd0);
        chk("rst_out_illegal", 32'(oi8), 32'd0);
        chk("rst_in_ready", 32'(ir8), 32'd1);
        chk("rst_out_valid32", 32'(ov32), 32'd0);

        // Directed ops with exact-latency checking.
        exact_lat = 1'b1;
        for (int op = 0; op < 5; op++) drive8(8'h96, 3, op);
        for (int op = 0; op < 5; op++) drive8(8'h96, 0, op);
        drive8(8'h01, 1, 0);
        drive8(8'h5A, 0, 6);
        drive8(8'h5A, 2, 5);
        drive8(8'hC3, 5, 7);
        @(negedge clk);
        chk("in_ready_unstalled", 32'(ir8), 32'd1);
        idle8(6);

        // Back-to-back random stream.
        for (int i = 0; i < 10; i++)
            drive8(8'($urandom), int'($urandom_range(0, 7)), int'($urandom_range(0, 7)));
        idle8(6);
        exact_lat = 1'b0;

        // Three ops in flight, then hold the consumer off for four cycles.
        for (int i = 0; i < 3; i++)
            drive8(8'($urandom), int'($urandom_range(1, 7)), int'($urandom_range(0, 4)));
        @(posedge clk);
        #1;
        iv8 = 1'b0;
        or8 = 1'b0;
        repeat (4) begin
            @(negedge clk);
            e = (q.size() != 0) ? 32'(q[0].d) : 'x;
            chk("stall_in_ready", 32'(ir8), 32'd0);
            chk("stall_out_valid", 32'(ov8), 32'd1);
            chk("stall_out_data", 32'(od8), e);
            chk("stall_q_depth", 32'(q.size()), 32'd3);
        end
        @(posedge clk);
        #1 or8 = 1'b1;
        idle8(6);
        chk("stall_drain", 32'(q.size()), 32'd0);

        // Reset with two ops in flight; an op offered during reset must be ignored.
        drive8(8'hF0, 1, 0);
        drive8(8'h0F, 2, 2);
        @(posedge clk);
        #1;
        rst  = 1'b1;
        iv8  = 1'b1;
        id8  = 8'hAA;
        in8  = 3'd1;
        iop8 = 3'd3;
        @(posedge clk);
        #1;
        rst = 1'b0;
        iv8 = 1'b0;
        @(negedge clk);
        chk("flush_out_valid", 32'(ov8), 32'd0);
        chk("flush_out_data", 32'(od8), 32'd0);
        chk("flush_in_ready", 32'(ir8), 32'd1);
        idle8(8);
        chk("flush_no_stale", 32'(q.size()), 32'd0);

        // Random traffic with random backpressure.
        for (int i = 0; i < 300; i++) begin
            @(posedge clk);
            #1;
            iv8  = ($urandom_range(0, 3) != 0);
            id8  = 8'($urandom);
            in8  = 3'($urandom_range(0, 7));
            iop8 = 3'($urandom_range(0, 7));
            or8  = ($urandom_range(0, 2) != 0);
        end
        @(posedge clk);
        #1;
        iv8 = 1'b0;
        or8 = 1'b1;
        idle8(10);
        chk("final_drain", 32'(q.size()), 32'd0);

        // 32-bit instance.
        run32(32'h8000_0000, 31, 1);
        run32(32'h8000_0001, 1, 4);
        run32(32'h1234_5678, 0, 3);
        run32(32'hDEAD_BEEF, 4, 6);
        for (int i = 0; i < 6; i++)
            run32($urandom, int'($urandom_range(0, 31)), int'($urandom_range(0, 7)));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
